// File: rtl/pwm_fade_ctrl.sv
// Bus-programmable duty-cycle fader for the PWM core; duty and period only change on period boundaries.
// Optional ping-pong ramping between start duty and target is enabled by defining PWM_FADE_BOUNCE_EN.
module pwm_fade_ctrl #(
  parameter int W      = 11,
  parameter int HOLD_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic          cs,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic [W-1:0]  pwmNum,
  output logic [W-1:0]  comparatorNum,
  output logic          irq
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RAMP = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state, state_d;
  logic [W-1:0]      cnt, pwm_num, period_sh, target, step, cur, cur_d;
  logic [HOLD_W-1:0] hold, hold_cnt, hold_d;
  logic              irq_en, done_flag, done_set;
  logic              tick, endpoint;
  logic [7:0]        wr_sel;
  logic              start_req, stop_req, start_ok;
  logic [W-1:0]      dest, diff, stepped;
  logic [HOLD_W:0]   hold_inc, hold_eff;
  logic              step_due;
  logic              unused_bits;

`ifdef PWM_FADE_BOUNCE_EN
  logic              bounce, dest_is_start, dir_flip;
  logic [W-1:0]      start_duty;
`endif

  assign unused_bits = ^{wdata[31:W], addr[31:5], addr[1:0]};

  always_comb begin
    wr_sel = '0;
    if (we && cs) wr_sel[addr[4:2]] = 1'b1;
  end

  assign start_req = wr_sel[0] & wdata[0];
  assign stop_req  = wr_sel[0] & wdata[3];
  assign start_ok  = start_req & ~stop_req & (state != S_DONE);

  // Mirror of the PWM core counter; pwm_num - 1 wraps so pwm_num == 0 counts the full range.
  assign tick = (cnt == pwm_num - W'(1));

`ifdef PWM_FADE_BOUNCE_EN
  assign dest = dest_is_start ? start_duty : target;
`else
  assign dest = target;
`endif

  always_comb begin
    diff     = (dest >= cur) ? (dest - cur) : (cur - dest);
    if (step == '0 || diff <= step) stepped = dest;
    else if (dest > cur)            stepped = cur + step;
    else                            stepped = cur - step;
    hold_inc = {1'b0, hold_cnt} + (HOLD_W+1)'(1);
    hold_eff = (hold == '0) ? (HOLD_W+1)'(1) : {1'b0, hold};
    step_due = (hold_inc >= hold_eff);
  end

  always_comb begin
    state_d  = state;
    cur_d    = cur;
    hold_d   = hold_cnt;
    done_set = 1'b0;
    endpoint = 1'b0;
`ifdef PWM_FADE_BOUNCE_EN
    dir_flip = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (wr_sel[6]) cur_d = wdata[W-1:0];
        if (start_req) begin
          state_d = S_RAMP;
          hold_d  = '0;
        end
      end
      S_RAMP: begin
        if (start_req) begin
          hold_d = '0;
        end else if (tick) begin
          if (cur == dest) begin
            endpoint = 1'b1;
          end else if (step_due) begin
            hold_d   = '0;
            cur_d    = stepped;
            endpoint = (stepped == dest);
          end else begin
            hold_d = hold_inc[HOLD_W-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (endpoint) begin
`ifdef PWM_FADE_BOUNCE_EN
      if (bounce) begin
        dir_flip = 1'b1;
        hold_d   = '0;
      end else
`endif
      begin
        state_d  = S_DONE;
        done_set = 1'b1;
      end
    end

    // STOP overrides any step or endpoint decided on the same edge.
    if (stop_req) begin
      state_d  = S_IDLE;
      cur_d    = cur;
      hold_d   = hold_cnt;
      done_set = 1'b0;
`ifdef PWM_FADE_BOUNCE_EN
      dir_flip = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      pwm_num   <= '0;
      period_sh <= '0;
      target    <= '0;
      step      <= '0;
      hold      <= '0;
      hold_cnt  <= '0;
      cur       <= '0;
      irq_en    <= 1'b0;
      done_flag <= 1'b0;
`ifdef PWM_FADE_BOUNCE_EN
      bounce        <= 1'b0;
      dest_is_start <= 1'b0;
      start_duty    <= '0;
`endif
    end else begin
      cnt <= tick ? '0 : cnt + W'(1);
      if (tick || state == S_IDLE) pwm_num <= period_sh;
      if (wr_sel[0]) irq_en    <= wdata[2];
      if (wr_sel[1]) period_sh <= wdata[W-1:0];
      if (wr_sel[2]) target    <= wdata[W-1:0];
      if (wr_sel[3]) step      <= wdata[W-1:0];
      if (wr_sel[4]) hold      <= wdata[HOLD_W-1:0];
      if (done_set)                    done_flag <= 1'b1;
      else if (wr_sel[5] && wdata[1])  done_flag <= 1'b0;
      state    <= state_d;
      cur      <= cur_d;
      hold_cnt <= hold_d;
`ifdef PWM_FADE_BOUNCE_EN
      if (wr_sel[0]) bounce <= wdata[1];
      if (start_ok) begin
        start_duty    <= cur;
        dest_is_start <= 1'b0;
      end else if (dir_flip) begin
        dest_is_start <= ~dest_is_start;
      end
`endif
    end
  end

  always_comb begin
    rdata = '0;
    case (addr[4:2])
      3'd0: begin
        rdata[2] = irq_en;
`ifdef PWM_FADE_BOUNCE_EN
        rdata[1] = bounce;
`endif
      end
      3'd1: rdata[W-1:0]      = period_sh;
      3'd2: rdata[W-1:0]      = target;
      3'd3: rdata[W-1:0]      = step;
      3'd4: rdata[HOLD_W-1:0] = hold;
      3'd5: rdata[1:0]        = {done_flag, state == S_RAMP};
      3'd6: rdata[W-1:0]      = cur;
      default: rdata = '0;
    endcase
  end

  assign pwmNum        = pwm_num;
  assign comparatorNum = cur;
  assign irq           = done_flag & irq_en;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl: register map, ramp timing, clamping, period shadowing, STOP and reset.
module tb_pwm_fade_ctrl;
  localparam int W      = 11;
  localparam int HOLD_W = 8;

  logic          clk = 1'b0;
  logic          reset, we, cs, irq;
  logic [31:0]   addr, wdata, rdata;
  logic [W-1:0]  pwmNum, comparatorNum;
  int            vectors = 0;
  int            errors  = 0;

  always #5 clk = ~clk;

  pwm_fade_ctrl #(.W(W), .HOLD_W(HOLD_W)) dut (
    .clk(clk), .reset(reset), .we(we), .cs(cs), .addr(addr), .wdata(wdata),
    .rdata(rdata), .pwmNum(pwmNum), .comparatorNum(comparatorNum), .irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [2:0] idx, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; cs = 1'b1; addr = {27'd0, idx, 2'b00}; wdata = d;
    @(posedge clk); #1;
    we = 1'b0; cs = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] idx, input logic [31:0] exp);
    addr = {27'd0, idx, 2'b00};
    #1;
    chk(tag, rdata, exp);
  endtask

  // Waits for the next duty update, then checks its value and (if exp_gap > 0) its spacing in clocks.
  task automatic step_chk(input string tag, input int exp_gap, input logic [W-1:0] exp_val);
    logic [W-1:0] prev;
    int cycles;
    prev = comparatorNum;
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (comparatorNum === prev && cycles < 80);
    vectors++;
    assert (comparatorNum !== prev) else begin
      errors++;
      $error("FAIL %s_timeout: got 0x%0h unchanged, want 0x%0h", tag, comparatorNum, exp_val);
    end
    chk({tag, "_val"}, 32'(comparatorNum), 32'(exp_val));
    if (exp_gap > 0) chk({tag, "_gap"}, 32'(cycles), 32'(exp_gap));
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; cs = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pwmNum", 32'(pwmNum), 32'd0);
    chk("rst_cmp", 32'(comparatorNum), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) rd_chk("rst_reg", 3'(i), 32'd0);

    // Ramp 0 -> 6 by 2, one step every 3 periods of 10 clocks
    bus_wr(3'd1, 32'd10);
    bus_wr(3'd6, 32'd0);
    bus_wr(3'd2, 32'd6);
    bus_wr(3'd3, 32'd2);
    bus_wr(3'd4, 32'd3);
    chk("a_pwmNum", 32'(pwmNum), 32'd10);
    bus_wr(3'd0, 32'h5);
    rd_chk("a_ctrl_rd", 3'd0, 32'h4);
    step_chk("a_s1", 0, 11'd2);
    rd_chk("a_busy", 3'd5, 32'h1);
    chk("a_irq_lo", 32'(irq), 32'd0);
    step_chk("a_s2", 30, 11'd4);
    step_chk("a_s3", 30, 11'd6);
    rd_chk("a_done", 3'd5, 32'h2);
    chk("a_irq_hi", 32'(irq), 32'd1);
    bus_wr(3'd5, 32'h2);
    chk("a_irq_clr", 32'(irq), 32'd0);
    rd_chk("a_stat_clr", 3'd5, 32'h0);

    // Downward ramp 7 -> 2 by 3 clamps at the target
    bus_wr(3'd6, 32'd7);
    bus_wr(3'd2, 32'd2);
    bus_wr(3'd3, 32'd3);
    bus_wr(3'd4, 32'd1);
    chk("b_cmp7", 32'(comparatorNum), 32'd7);
    bus_wr(3'd0, 32'h5);
    step_chk("b_s1", 0, 11'd4);
    step_chk("b_s2", 10, 11'd2);
    rd_chk("b_done", 3'd5, 32'h2);
    chk("b_irq_hi", 32'(irq), 32'd1);
    bus_wr(3'd5, 32'h2);
    chk("b_irq_clr", 32'(irq), 32'd0);
    rd_chk("b_stat_clr", 3'd5, 32'h0);

    // PERIOD 10 -> 20 mid-period while ramping by 1 per period
    bus_wr(3'd6, 32'd0);
    bus_wr(3'd2, 32'd2000);
    bus_wr(3'd3, 32'd1);
    bus_wr(3'd0, 32'h5);
    step_chk("c_s1", 0, 11'd1);
    step_chk("c_s2", 10, 11'd2);
    repeat (2) @(posedge clk);
    #1;
    bus_wr(3'd1, 32'd20);
    chk("c_pwm_old", 32'(pwmNum), 32'd10);
    rd_chk("c_period_rd", 3'd1, 32'd20);
    step_chk("c_s3", 7, 11'd3);
    chk("c_pwm_new", 32'(pwmNum), 32'd20);
    step_chk("c_s4", 20, 11'd4);

    // Back to period 10 at a tick, then STOP holds the duty
    bus_wr(3'd1, 32'd10);
    step_chk("d_s0", 19, 11'd5);
    chk("d_pwm10", 32'(pwmNum), 32'd10);
    bus_wr(3'd0, 32'h8);
    rd_chk("d_stop_stat", 3'd5, 32'h0);
    bus_wr(3'd6, 32'd0);
    bus_wr(3'd2, 32'd8);
    bus_wr(3'd3, 32'd2);
    bus_wr(3'd0, 32'h5);
    step_chk("d_s1", 0, 11'd2);
    step_chk("d_s2", 10, 11'd4);
    bus_wr(3'd0, 32'h9);
    rd_chk("d_ss_stat", 3'd5, 32'h0);
    repeat (25) @(posedge clk);
    #1;
    chk("d_hold_cmp", 32'(comparatorNum), 32'd4);
    rd_chk("d_hold_stat", 3'd5, 32'h0);
    bus_wr(3'd6, 32'd1);
    rd_chk("d_cur_rd", 3'd6, 32'd1);
    chk("d_cur_cmp", 32'(comparatorNum), 32'd1);

    bus_wr(3'd0, 32'h6);
`ifdef PWM_FADE_BOUNCE_EN
    rd_chk("ctrl_bounce_rd", 3'd0, 32'h6);
`else
    rd_chk("ctrl_bounce_rd", 3'd0, 32'h4);
`endif
    bus_wr(3'd0, 32'h4);

`ifdef PWM_FADE_BOUNCE_EN
    bus_wr(3'd6, 32'd0);
    bus_wr(3'd2, 32'd4);
    bus_wr(3'd3, 32'd2);
    bus_wr(3'd0, 32'h3);
    step_chk("e_s1", 0, 11'd2);
    step_chk("e_s2", 10, 11'd4);
    step_chk("e_s3", 10, 11'd2);
    step_chk("e_s4", 10, 11'd0);
    rd_chk("e_no_done", 3'd5, 32'h1);
    step_chk("e_s5", 10, 11'd2);
    bus_wr(3'd0, 32'h0);
    step_chk("e_s6", 9, 11'd4);
    rd_chk("e_done", 3'd5, 32'h2);
    bus_wr(3'd5, 32'h2);
    bus_wr(3'd0, 32'h4);
`endif

    // Asynchronous reset in the middle of a ramp
    bus_wr(3'd6, 32'd0);
    bus_wr(3'd2, 32'd8);
    bus_wr(3'd3, 32'd2);
    bus_wr(3'd4, 32'd1);
    bus_wr(3'd0, 32'h5);
    step_chk("f_s1", 0, 11'd2);
    rd_chk("f_busy", 3'd5, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("f_pwmNum", 32'(pwmNum), 32'd0);
    chk("f_cmp", 32'(comparatorNum), 32'd0);
    chk("f_irq", 32'(irq), 32'd0);
    for (int i = 0; i < 8; i++) rd_chk("f_reg", 3'(i), 32'd0);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/pwm_fade_ctrl.md
Name: pwm_fade_ctrl

Overview:
Memory-mapped sequencer that drives the pwmNum/comparatorNum configuration inputs of the PWM IP core and ramps the duty cycle from its current value toward a programmed target. Duty changes only at PWM period boundaries, so no glitched periods occur. The boundaries come from an internal mirror counter that runs in lock-step with the PWM core's counter. The block sits on the CPU peripheral bus beside the PWM core and replaces that core's bus-register front end when fading is required.

Parameters:
W, 11, width of period/duty values (matches PWM core counter)
HOLD_W, 8, width of HOLD register (periods per step)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
we  input  1  bus write strobe
cs  input  1  chip select; a write occurs when we & cs
addr  input  32  byte address; register index is addr[4:2]
wdata  input  32  write data
rdata  output  32  combinational read data
pwmNum  output  W  period to PWM core
comparatorNum  output  W  duty to PWM core
irq  output  1  level interrupt, = DONE & IRQ_EN

Behaviour:
- Register map (index = addr[4:2]):
  - 0 CTRL: bit0 START (write-1 pulse, reads 0); bit1 BOUNCE; bit2 IRQ_EN; bit3 STOP (write-1 pulse, reads 0).
  - 1 PERIOD[W-1:0]; 2 TARGET[W-1:0]; 3 STEP[W-1:0]; 4 HOLD[HOLD_W-1:0].
  - 5 STATUS: bit0 BUSY (RO); bit1 DONE (sticky, write-1-to-clear).
  - 6 CUR[W-1:0]: writable only in IDLE; writes in other states are ignored.
  - 7: reads 0, writes ignored.
- rdata is combinational from addr; unused bits read 0.
- Reset clears every register, the mirror counter and the state. pwmNum=0, comparatorNum=0, irq=0, state IDLE.
- Mirror counter:
  - Identical to the PWM core's counter: resets to 0, returns to 0 when cnt == pwmNum-1 (W-bit arithmetic, so pwmNum=0 wraps at 2^W-1), otherwise increments.
  - tick = (cnt == pwmNum-1), asserted for one clk.
- Shadowing:
  - A PERIOD write updates a shadow register. pwmNum loads the shadow on the next tick (in any state), and also whenever state is IDLE.
  - comparatorNum always equals CUR. CUR changes only at a tick, except for direct writes in IDLE.
- FSM states: IDLE, RAMP, DONE.
  - IDLE: START -> RAMP; hold_cnt cleared.
  - RAMP, on each tick:
    - hold_cnt++.
    - When hold_cnt reaches max(HOLD,1): hold_cnt=0 and a step is applied.
    - Step: if STEP==0 or |TARGET-CUR| <= STEP, then CUR = TARGET; else CUR moves toward TARGET by STEP (no overshoot, unsigned, never wraps).
    - If CUR == TARGET after the update: go to DONE, and set the DONE flag on the same edge.
  - RAMP when CUR == TARGET at START: go to DONE on the first tick, with no hold wait.
  - DONE: go to IDLE on the next clk; BUSY=0.
  - BUSY=1 only in RAMP.
- START while in RAMP restarts hold_cnt and continues from the current CUR toward the current TARGET. TARGET/STEP/HOLD writes during RAMP take effect at the next step.
- STOP in any state -> IDLE on the next clk; CUR is retained. STOP and START in the same write: STOP wins.
- A DONE write-1-to-clear on the same clk that DONE is being set: set wins.
- Reset mid-ramp: everything returns to reset values immediately, asynchronously.

Optional Feature:
- Macro: PWM_FADE_BOUNCE_EN.
- Defined:
  - START latches the start duty (the CUR value at START).
  - With BOUNCE=1, reaching TARGET swaps the ramp direction toward the start duty instead of entering DONE. The ramp oscillates indefinitely; DONE is never set. Exit is by STOP, or by clearing BOUNCE, after which the next endpoint enters DONE.
- Undefined: CTRL bit1 is not stored, reads 0, and has no effect.

Test Plan:
- Reset mid-RAMP -> pwmNum=0, comparatorNum=0, irq=0, STATUS=0, and all registers read 0.
- PERIOD=10, CUR=0, TARGET=6, STEP=2, HOLD=3, START -> comparatorNum 2,4,6 at ticks 3,6,9 (tick every 10 clk); DONE set at the 6 update; BUSY falls; irq=1 when IRQ_EN=1.
- CUR=7, TARGET=2, STEP=3, HOLD=1 -> comparatorNum 4 then 2 (clamped, no underflow); DONE=1; writing STATUS=0x2 clears DONE and drops irq.
- PERIOD written 10->20 mid-period -> pwmNum changes exactly at the next tick, and the mirror counter stays aligned with the PWM core counter (its wrap occurs at 9, then 19).
- STOP together with START during RAMP at CUR=4 -> IDLE, CUR holds 4, BUSY=0, DONE unchanged; a subsequent CUR write to 1 reads back 1.
- (PWM_FADE_BOUNCE_EN) CUR=0, TARGET=4, STEP=2, HOLD=1, BOUNCE=1 -> comparatorNum 2,4,2,0,2,... with DONE never set; clear BOUNCE -> stops at the next endpoint and DONE=1.
